car_sensor_conditioner: RTL and testbench

- Upstream stage of the traffic light controller. Takes the raw side-road loop detector input and conditions it into the controller's `car_sensor` request.
- Conditioning steps: synchronise, debounce, then latch a request and hold it until the controller serves the side road.
- After service, ignores the detector for a hold-off window so the side road cannot immediately re-request.
- Flags a detector that stays stuck asserted.

---
 rtl/car_sensor_conditioner.sv | 166 ++++++++++++++++
 tb/tb_car_sensor_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/car_sensor_conditioner.sv
// Conditions the raw side-road loop detector into the controller's car_sensor
// request: two-flop synchroniser, debounce, request latch held until the side
// road is served, post-service hold-off, and a sticky stuck-detector flag.
module car_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int HOLDOFF_CYCLES  = 2000,
    parameter int STUCK_CYCLES    = 120000,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       raw_sensor,
    input  logic [2:0] light_2,
    output logic       car_sensor,
    output logic       sensor_stable,
    output logic       holdoff_active,
    output logic       fault
);

    localparam logic [2:0] LIGHT_GREEN = 3'b001;
    localparam logic [2:0] LIGHT_RED   = 3'b100;
    localparam logic [2:0] LIGHT_RESET = 3'b111;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVED,
        HOLDOFF
    } state_t;

    logic [1:0]       sync_reg;
    logic             sync;
    logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic             stable_reg, stable_next;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             car_reg, holdoff_reg;
    logic [CNT_W-1:0] stuck_cnt_reg, stuck_cnt_next;
    logic             fault_reg, fault_next;

    assign sync = sync_reg[1];

    // Two-flop synchroniser; the first stage captures raw_sensor with no logic in front.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], raw_sensor};
        end
    end

    // Debounce: the stable level only follows sync after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_next  = stable_reg;
        deb_cnt_next = '0;
        if (sync != stable_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
                stable_next = ~stable_reg;
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            deb_cnt_reg <= '0;
            stable_reg  <= 1'b0;
        end else begin
            deb_cnt_reg <= deb_cnt_next;
            stable_reg  <= stable_next;
        end
    end

    // Request FSM next state; the controller-reset code overrides every other transition.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        if (light_2 == LIGHT_RESET) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (stable_reg) begin
                        state_next = REQUEST;
                    end
                end
                REQUEST: begin
                    // Once raised, the request stays up until the side road actually goes green.
                    if (light_2 == LIGHT_GREEN) begin
                        state_next = SERVED;
                    end
                end
                SERVED: begin
                    if (light_2 == LIGHT_RED) begin
                        state_next    = HOLDOFF;
                        hold_cnt_next = '0;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    // FSM state, hold-off counter and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            car_reg      <= 1'b0;
            holdoff_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            car_reg      <= (state_next == REQUEST);
            holdoff_reg  <= (state_next == HOLDOFF);
        end
    end

    // Stuck detection: saturating count of debounced-high cycles; fault latches when it reaches the limit.
    always_comb begin
        stuck_cnt_next = '0;
        fault_next     = fault_reg;
        if (stable_reg) begin
            stuck_cnt_next = (stuck_cnt_reg == STUCK_MAX) ? stuck_cnt_reg : stuck_cnt_reg + 1'b1;
            if (stuck_cnt_reg == STUCK_LAST) begin
                fault_next = 1'b1;
            end
        end
    end

    // Stuck counter and sticky fault registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuck_cnt_reg <= '0;
            fault_reg     <= 1'b0;
        end else begin
            stuck_cnt_reg <= stuck_cnt_next;
            fault_reg     <= fault_next;
        end
    end

    assign car_sensor     = car_reg;
    assign sensor_stable  = stable_reg;
    assign holdoff_active = holdoff_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed bench for car_sensor_conditioner: expected outputs are queued when
// stimulus is applied and compared against the DUT once the cycle completes.
module tb_car_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int STUCK = 100;

    localparam logic [3:0] M_CAR = 4'b0001;
    localparam logic [3:0] M_STB = 4'b0010;
    localparam logic [3:0] M_HLD = 4'b0100;
    localparam logic [3:0] M_FLT = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       raw_sensor;
    logic [2:0] light_2;
    logic       car_sensor;
    logic       sensor_stable;
    logic       holdoff_active;
    logic       fault;

    int checks = 0;
    int errors = 0;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    car_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD),
        .STUCK_CYCLES   (STUCK),
        .CNT_W          (17)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .raw_sensor    (raw_sensor),
        .light_2       (light_2),
        .car_sensor    (car_sensor),
        .sensor_stable (sensor_stable),
        .holdoff_active(holdoff_active),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs_vec();
        return {fault, holdoff_active, sensor_stable, car_sensor};
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] mask, input logic [3:0] val);
        tag_q.push_back(tag);
        exp_q.push_back({mask, val & mask});
    endtask

    task automatic drain();
        string      t;
        logic [7:0] e;
        logic [3:0] o;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            o = obs_vec() & e[7:4];
            checks++;
            $display("step %s obs=%b exp=%b", t, o, e[3:0]);
            assert (o === e[3:0]) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", t, o, e[3:0]);
            end
        end
    endtask

    // Queue the expectation, let one clock edge pass, then compare.
    task automatic step(input string tag, input logic [3:0] mask, input logic [3:0] val);
        expect_out(tag, mask, val);
        @(posedge clk);
        #1;
        drain();
    endtask

    // Compare immediately (used for the asynchronous reset checks).
    task automatic now_check(input string tag, input logic [3:0] mask, input logic [3:0] val);
        expect_out(tag, mask, val);
        drain();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_rst      = 1'b0;
        raw_sensor = 1'b0;
        light_2    = 3'b100;
        #2;
        now_check("reset_all", M_ALL, 4'b0000);
        tick(1);
        n_rst = 1'b1;

        for (int i = 0; i < 20; i++) step("idle_quiet", M_ALL, 4'b0000);

        // Three-cycle glitch must never reach the debounced level.
        raw_sensor = 1'b1;
        for (int i = 0; i < 3; i++) step("glitch_hi", M_STB | M_CAR, 4'b0000);
        raw_sensor = 1'b0;
        for (int i = 0; i < 10; i++) step("glitch_after", M_STB | M_CAR, 4'b0000);

        // Held high: stable after edge DEB+1, request one edge later.
        raw_sensor = 1'b1;
        for (int i = 0; i < DEB + 1; i++) step("deb_wait", M_STB | M_CAR, 4'b0000);
        step("deb_stable", M_STB | M_CAR, 4'b0010);
        step("req_rise", M_STB | M_CAR, 4'b0011);

        // Detector drops: request is held.
        raw_sensor = 1'b0;
        for (int i = 0; i < 8; i++) step("req_hold", M_CAR, 4'b0001);
        step("req_drop_stable", M_STB | M_CAR, 4'b0001);

        light_2 = 3'b001;
        step("served", M_CAR | M_HLD, 4'b0000);
        light_2 = 3'b010;
        for (int i = 0; i < 3; i++) step("served_yellow", M_CAR | M_HLD, 4'b0000);
        light_2 = 3'b100;
        for (int i = 0; i < HOLD; i++) step("holdoff_on", M_CAR | M_HLD, 4'b0100);
        step("holdoff_off", M_CAR | M_HLD, 4'b0000);

        // Vehicle present through the whole hold-off.
        raw_sensor = 1'b1;
        for (int i = 0; i < DEB + 1; i++) step("deb2_wait", M_STB, 4'b0000);
        step("deb2_stable", M_STB | M_CAR, 4'b0010);
        step("req2_rise", M_CAR, 4'b0001);
        light_2 = 3'b001;
        step("served2", M_CAR, 4'b0000);
        light_2 = 3'b100;
        for (int i = 0; i < HOLD; i++) step("holdoff2_on", M_CAR | M_HLD | M_STB, 4'b0110);
        step("holdoff2_idle", M_CAR | M_HLD, 4'b0000);
        step("holdoff2_rereq", M_CAR | M_HLD, 4'b0001);

        // Controller reset code in REQUEST.
        light_2 = 3'b111;
        step("ctrl_reset", M_CAR | M_HLD, 4'b0000);
        light_2 = 3'b100;
        step("ctrl_reset_rereq", M_CAR, 4'b0001);

        raw_sensor = 1'b0;
        n_rst      = 1'b0;
        #1;
        now_check("rst_pulse", M_ALL, 4'b0000);
        tick(2);
        n_rst = 1'b1;

        // Stuck detector: stable rises after edge DEB+1, fault STUCK edges later.
        raw_sensor = 1'b1;
        tick(DEB + 1 + STUCK - 1);
        step("fault_before", M_FLT | M_STB, 4'b0010);
        step("fault_set", M_FLT | M_STB, 4'b1010);
        raw_sensor = 1'b0;
        tick(9);
        step("fault_sticky", M_FLT | M_STB, 4'b1000);
        n_rst = 1'b0;
        #1;
        now_check("fault_clear", M_ALL, 4'b0000);
        tick(2);
        n_rst = 1'b1;

        // Asynchronous reset in the middle of hold-off.
        raw_sensor = 1'b1;
        tick(DEB + 2);
        step("req3_rise", M_CAR, 4'b0001);
        raw_sensor = 1'b0;
        light_2    = 3'b001;
        step("served3", M_CAR, 4'b0000);
        light_2 = 3'b100;
        for (int i = 0; i < 4; i++) step("holdoff3_on", M_HLD, 4'b0100);
        #2;
        n_rst = 1'b0;
        #1;
        now_check("holdoff_async_rst", M_HLD | M_CAR, 4'b0000);
        tick(1);
        n_rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
